// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / RAW hazard controller.
// Scoreboard entries carry a fixed-width address field wide enough for any supported REG_ADDR_W.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 3;
  localparam int SB_ADDR_W      = 8;
  localparam int AGE_W          = 4;

  // Legal LOAD_LAT range is LOAD_LAT_MIN..PIPE_DEPTH
  localparam int LOAD_LAT_MIN   = 1;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic                 is_load;
    logic [AGE_W-1:0]     age;
    logic [SB_ADDR_W-1:0] dst;
  } sb_entry_t;

  // Out-of-range latencies are pulled back into the legal window
  function automatic int load_lat_legal(input int lat, input int depth);
    if (lat < LOAD_LAT_MIN) return LOAD_LAT_MIN;
    if (lat > depth)        return depth;
    return lat;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one source operand against every scoreboard entry and flags a blocking producer.
// LOAD_USE_FORWARDING_EN: only loads younger than LOAD_LAT block; otherwise any writer blocks.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int PIPE_DEPTH = 2,
  parameter int LOAD_LAT   = 1
) (
  input  sb_entry_t [PIPE_DEPTH-1:0] sb_i,
  input  logic [REG_ADDR_W-1:0]      src_i,
  input  logic                       used_i,
  input  logic                       id_valid_i,
  output logic                       block_o
);

`ifdef LOAD_USE_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [PIPE_DEPTH-1:0] hit;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_ent
    logic not_fwdable;
    // With forwarding, a producer stops blocking once its data can be bypassed
    assign not_fwdable = !FWD_EN ||
                         (sb_i[k].is_load && (int'(sb_i[k].age) < LOAD_LAT));
    assign hit[k] = sb_i[k].valid && sb_i[k].wr_en &&
                    (sb_i[k].dst == SB_ADDR_W'(src_i)) && not_fwdable;
  end

  assign block_o = used_i && id_valid_i && (|hit);

endmodule

// File: rtl/load_use_hazard_unit.sv
// ID-side hazard controller: scoreboard of in-flight producers, stall/bubble generation, stall counter.
// Optional macro LOAD_USE_FORWARDING_EN selects the forwarding-aware blocking rule.
module load_use_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_SRC    = 2,
  parameter int PIPE_DEPTH = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr,
  input  logic                          id_wr_en,
  input  logic                          id_is_load,
  input  logic                          flush,
  input  logic                          cnt_clr,
  output logic                          stall_fetch,
  output logic                          bubble_ex,
  output logic [NUM_SRC-1:0]            hazard_src,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int LAT_EFF = load_lat_legal(LOAD_LAT, PIPE_DEPTH);

  sb_entry_t [PIPE_DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_cmp #(
      .REG_ADDR_W (REG_ADDR_W),
      .PIPE_DEPTH (PIPE_DEPTH),
      .LOAD_LAT   (LAT_EFF)
    ) u_cmp (
      .sb_i       (sb_q),
      .src_i      (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .used_i     (id_src_used[i]),
      .id_valid_i (id_valid),
      .block_o    (hazard_src[i])
    );
  end

  // A flushed instruction is dead, so it must not hold the front end
  assign stall       = (|hazard_src) && !flush;
  assign stall_fetch = stall;
  assign bubble_ex   = stall;
  assign stall_cnt   = cnt_q;

  always_comb begin
    sb_d = '0;
    if (!stall && !flush && id_valid) begin
      sb_d[0].valid   = 1'b1;
      sb_d[0].wr_en   = id_wr_en;
      sb_d[0].is_load = id_is_load;
      sb_d[0].dst     = SB_ADDR_W'(id_dst_addr);
    end
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      sb_d[k]     = sb_q[k-1];
      sb_d[k].age = sb_q[k-1].age + AGE_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (stall && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
